// File: rtl/demux_dispatch.sv
// Round-robin dispatcher feeding a demux: holds one word, picks the next free
// channel starting at ptr, and strobes d/sel for one cycle per delivered word.
module demux_dispatch #(
  parameter int dwidth = 1,
  parameter int swidth = 1,
  parameter int cwidth = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [dwidth-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2**swidth-1:0] busy,
  output logic [dwidth-1:0]    d,
  output logic [swidth-1:0]    sel,
  output logic                 out_valid,
  output logic [cwidth-1:0]    sent_cnt,
  output logic [cwidth-1:0]    stall_cnt
);

  localparam int seln = 2**swidth;

  typedef enum logic [1:0] {EMPTY, HOLD, SEND} state_t;

  state_t            state;
  logic [dwidth-1:0] hold_data;
  logic [swidth-1:0] ptr;
  logic              found;
  logic [swidth-1:0] chan;
  logic [swidth-1:0] idx;

  assign in_ready = (state != HOLD);

  // Walk offsets from the far end back toward ptr so the closest free channel wins.
  always_comb begin
    found = 1'b0;
    chan  = ptr;
    idx   = ptr;
    for (int i = seln - 1; i >= 0; i--) begin
      idx = ptr + swidth'(i);
      if (!busy[idx]) begin
        found = 1'b1;
        chan  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      ptr       <= '0;
      hold_data <= '0;
      d         <= '0;
      sel       <= '0;
      out_valid <= 1'b0;
      sent_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            hold_data <= in_data;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (found) begin
            sel       <= chan;
            d         <= hold_data;
            out_valid <= 1'b1;
            ptr       <= chan + swidth'(1);
            state     <= SEND;
          end else if (stall_cnt != '1) begin
            stall_cnt <= stall_cnt + cwidth'(1);
          end
        end
        SEND: begin
          // Every SEND lasts one cycle, so the edge leaving it counts the word.
          d         <= '0;
          out_valid <= 1'b0;
          sent_cnt  <= sent_cnt + cwidth'(1);
          if (in_valid) begin
            hold_data <= in_data;
            state     <= HOLD;
          end else begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_dispatch.sv
// Scoreboard bench for demux_dispatch: stimulus pushes expected {sel,d} pairs,
// a negedge monitor pops and compares on every out_valid strobe.
module tb_demux_dispatch;

  localparam int DW = 8;
  localparam int SW = 2;
  localparam int CW = 4;

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [DW-1:0] d;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_ready;
  logic [2**SW-1:0] busy;
  logic [DW-1:0]   d;
  logic [SW-1:0]   sel;
  logic            out_valid;
  logic [CW-1:0]   sent_cnt;
  logic [CW-1:0]   stall_cnt;

  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;
  exp_t q[$];

  demux_dispatch #(.dwidth(DW), .swidth(SW), .cwidth(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy), .d(d), .sel(sel), .out_valid(out_valid),
    .sent_cnt(sent_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest expected delivery, d is zero otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_pulse: got sel=%0d d=0x%0h expected no pulse at %0t", sel, d, $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          check_output("deliver_sel", 32'(sel), 32'(e.sel));
          check_output("deliver_d", 32'(d), 32'(e.d));
        end
      end else begin
        check_output("idle_d_zero", 32'(d), 32'h0);
      end
    end
  end

  // Offer one word and wait for its accepting edge; optionally keep in_valid high for streaming.
  task automatic apply_stimulus(input logic [DW-1:0] data, input bit push, input logic [SW-1:0] exp_sel,
                                input bit keep_valid);
    int n = 0;
    in_data  = data;
    in_valid = 1'b1;
    if (push) q.push_back({exp_sel, data});
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: got in_ready=%b expected 1 within 50 cycles", in_ready);
    end
    @(posedge clk); #1;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout: got %0d pending deliveries expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic reset_dut();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    busy     = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with a word offered: nothing may be captured.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h99;
    busy     = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    check_output("reset_in_ready", 32'(in_ready), 32'h1);
    check_output("reset_out_valid", 32'(out_valid), 32'h0);
    check_output("reset_d", 32'(d), 32'h0);
    check_output("reset_sel", 32'(sel), 32'h0);
    check_output("reset_sent_cnt", 32'(sent_cnt), 32'h0);
    check_output("reset_stall_cnt", 32'(stall_cnt), 32'h0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_no_capture", 32'(in_ready), 32'h1);

    // Round robin streaming with no busy channels.
    reset_dut();
    apply_stimulus(8'h11, 1, 2'd0, 1);
    apply_stimulus(8'h22, 1, 2'd1, 1);
    apply_stimulus(8'h33, 1, 2'd2, 1);
    apply_stimulus(8'h44, 1, 2'd3, 1);
    apply_stimulus(8'h55, 1, 2'd0, 0);
    drain();
    check_output("rr_sent_cnt", 32'(sent_cnt), 32'd5);

    // Busy skip: ptr=1, channels 1 and 2 busy.
    reset_dut();
    apply_stimulus(8'h10, 1, 2'd0, 0);
    drain();
    busy = 4'b0110;
    apply_stimulus(8'hA5, 1, 2'd3, 0);
    drain();
    busy = 4'b0000;
    apply_stimulus(8'h5A, 1, 2'd0, 0);
    drain();

    // All busy for 5 cycles, then release channel 2.
    reset_dut();
    busy = 4'b1111;
    apply_stimulus(8'h3C, 1, 2'd2, 0);
    for (int i = 0; i < 5; i++) begin
      check_output("allbusy_out_valid", 32'(out_valid), 32'h0);
      check_output("allbusy_in_ready", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
    end
    check_output("allbusy_stall_cnt", 32'(stall_cnt), 32'd5);
    busy = 4'b1011;
    @(posedge clk); #1;
    check_output("release_out_valid", 32'(out_valid), 32'h1);
    drain();

    // Reset while holding 0x7E: the held word must vanish.
    reset_dut();
    busy = 4'b1111;
    apply_stimulus(8'h7E, 0, 2'd0, 0);
    @(posedge clk); #1;
    check_output("midrst_holding", 32'(in_ready), 32'h0);
    rst_n = 1'b0;
    busy  = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_output("midrst_in_ready", 32'(in_ready), 32'h1);
    check_output("midrst_out_valid", 32'(out_valid), 32'h0);
    check_output("midrst_stall_cnt", 32'(stall_cnt), 32'h0);
    repeat (5) @(posedge clk);
    #1;
    apply_stimulus(8'h81, 1, 2'd0, 0);
    drain();

    // Counter limits: sent_cnt wraps, stall_cnt saturates.
    reset_dut();
    for (int i = 0; i < 17; i++)
      apply_stimulus(DW'(i + 1), 1, SW'(i % 4), (i < 16));
    drain();
    check_output("sent_cnt_wrap", 32'(sent_cnt), 32'd1);
    busy = 4'b1111;
    apply_stimulus(8'hC3, 1, 2'd1, 0);
    repeat (20) @(posedge clk);
    #1;
    check_output("stall_cnt_sat", 32'(stall_cnt), 32'd15);
    busy = 4'b0000;
    drain();
    check_output("final_sent_cnt", 32'(sent_cnt), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
